// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_EXC,
    SRC_BR,
    SRC_PEND,
    SRC_JMP,
    SRC_RET
  } redirect_src_t;

  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: the oldest entry is overwritten when full,
// and a simultaneous push/pop replaces the top entry in place.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [PW-1:0]    ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    top_idx;
  logic             pop_ok;

  // ptr_reg is the next free slot; the top entry sits just below it.
  assign top_idx  = ptr_reg - PW'(1);
  assign top_data = mem[top_idx];
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(RAS_DEPTH));
  assign pop_ok   = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push && pop_ok) begin
      ptr_reg   <= ptr_reg;
      count_reg <= count_reg;
    end else if (push) begin
      ptr_reg <= ptr_reg + PW'(1);
      if (!full)
        count_reg <= count_reg + CW'(1);
    end else if (pop_ok) begin
      ptr_reg   <= top_idx;
      count_reg <= count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[pop_ok ? top_idx : ptr_reg] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: priority next-PC mux, stall-time redirect capture
// and return-address-stack prediction for jr $ra.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             exc_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] call_link_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             redirect_o,
  output logic             ras_empty_o,
  output logic             ras_full_o
);

  logic [WIDTH-1:0] pc_reg;
  logic             redirect_reg;
  logic             pend_valid_reg;
  logic [WIDTH-1:0] pend_target_reg;

  redirect_src_t    src;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_push;
  logic             ras_pop;

  assign pc_o        = pc_reg;
  assign pc_plus4_o  = pc_reg + WIDTH'(INSTR_BYTES);
  assign redirect_o  = redirect_reg;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

  // The stack only moves on an unstalled, exception-free cycle; a ret pops
  // even when a higher-priority source wins the mux.
  assign ras_push = call_i && !stall_i && !exc_i;
  assign ras_pop  = ret_i  && !stall_i && !exc_i;

  always_comb begin
    src     = SRC_SEQ;
    pc_next = pc_plus4_o;
    if (exc_i) begin
      src     = SRC_EXC;
      pc_next = EXC_VECTOR;
    end else if (br_taken_i) begin
      src     = SRC_BR;
      pc_next = br_target_i;
    end else if (pend_valid_reg) begin
      src     = SRC_PEND;
      pc_next = pend_target_reg;
    end else if (jump_i) begin
      src     = SRC_JMP;
      pc_next = jump_target_i;
    end else if (ret_i && !ras_empty) begin
      src     = SRC_RET;
      pc_next = ras_top;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_reg          <= RESET_VECTOR;
      redirect_reg    <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
    end else if (exc_i) begin
      pc_reg         <= EXC_VECTOR;
      redirect_reg   <= 1'b1;
      pend_valid_reg <= 1'b0;
    end else if (stall_i) begin
      redirect_reg <= 1'b0;
      // A branch from EX is older than anything in ID, so it always wins.
      if (br_taken_i) begin
        pend_valid_reg  <= 1'b1;
        pend_target_reg <= br_target_i;
      end else if (jump_i && !pend_valid_reg) begin
        pend_valid_reg  <= 1'b1;
        pend_target_reg <= jump_target_i;
      end
    end else begin
      pc_reg         <= pc_next;
      redirect_reg   <= (src != SRC_SEQ);
      pend_valid_reg <= 1'b0;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (call_link_i),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential fetch, stalled redirects, priority,
// exceptions, RAS push/pop behaviour and asynchronous reset.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        exc = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        call = 1'b0;
  logic [31:0] call_link = '0;
  logic        ret = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        ras_empty;
  logic        ras_full;

  int checks = 0;
  int failures = 0;

  pc_gen dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .exc_i         (exc),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .jump_i        (jump),
    .jump_target_i (jump_target),
    .call_i        (call),
    .call_link_i   (call_link),
    .ret_i         (ret),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .redirect_o    (redirect),
    .ras_empty_o   (ras_empty),
    .ras_full_o    (ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_pc(input string tag, input logic [31:0] exp_pc, input logic exp_redir);
    step();
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_redir"}, {31'd0, redirect}, {31'd0, exp_redir});
    $display("step %s pc=0x%08h redirect=%0b ras_empty=%0b ras_full=%0b",
             tag, pc, redirect, ras_empty, ras_full);
  endtask

  logic [31:0] links [5];
  logic [31:0] rets  [4];

  initial begin
    links = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    rets  = '{32'h50, 32'h40, 32'h30, 32'h20};

    // Reset state
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_redir", {31'd0, redirect}, 32'd0);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_full", {31'd0, ras_full}, 32'd0);
    chk("rst_plus4", pc_plus4, 32'h4);
    rst = 1'b0;

    // Sequential fetch
    step_pc("seq1", 32'h4, 1'b0);
    step_pc("seq2", 32'h8, 1'b0);
    step_pc("seq3", 32'hC, 1'b0);

    // Jump captured during a stall, applied on release
    stall = 1'b1; jump = 1'b1; jump_target = 32'h100;
    step_pc("stall1", 32'hC, 1'b0);
    jump = 1'b0;
    step_pc("stall2", 32'hC, 1'b0);
    stall = 1'b0;
    step_pc("pend_apply", 32'h100, 1'b1);
    step_pc("after_pend", 32'h104, 1'b0);

    // Branch beats jump and pending; pending is discarded
    stall = 1'b1; jump = 1'b1; jump_target = 32'h400;
    step_pc("pend400", 32'h104, 1'b0);
    stall = 1'b0; br_taken = 1'b1; br_target = 32'h200; jump_target = 32'h300;
    step_pc("prio_br", 32'h200, 1'b1);
    br_taken = 1'b0; jump = 1'b0;
    step_pc("pend_cleared", 32'h204, 1'b0);

    // Exception while stalled kills the pending redirect
    stall = 1'b1; jump = 1'b1; jump_target = 32'h100;
    step_pc("pend100", 32'h204, 1'b0);
    jump = 1'b0; exc = 1'b1;
    step_pc("exc", 32'h80, 1'b1);
    exc = 1'b0; stall = 1'b0;
    step_pc("after_exc", 32'h84, 1'b0);

    // Five calls into a four-deep RAS
    call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      call_link = links[i];
      step_pc($sformatf("call%0d", i), 32'h88 + 32'(4 * i), 1'b0);
      chk($sformatf("call%0d_full", i), {31'd0, ras_full}, {31'd0, (i >= 3)});
    end
    call = 1'b0;

    ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_pc($sformatf("ret%0d", i), rets[i], 1'b1);
    end
    chk("ras_drained", {31'd0, ras_empty}, 32'd1);
    step_pc("ret_empty", 32'h24, 1'b0);
    ret = 1'b0;

    // Call and ret together replace the top entry
    call = 1'b1; call_link = 32'h600;
    step_pc("call600", 32'h28, 1'b0);
    ret = 1'b1; call_link = 32'h700;
    step_pc("callret", 32'h600, 1'b1);
    chk("callret_nonempty", {31'd0, ras_empty}, 32'd0);
    call = 1'b0;
    step_pc("ret700", 32'h700, 1'b1);
    chk("ret700_empty", {31'd0, ras_empty}, 32'd1);
    ret = 1'b0;

    // Asynchronous reset mid-stall with a pending redirect and a live RAS entry
    call = 1'b1; call_link = 32'h123;
    step_pc("call123", 32'h704, 1'b0);
    call = 1'b0; stall = 1'b1; jump = 1'b1; jump_target = 32'h900;
    step_pc("pend900", 32'h704, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_redir", {31'd0, redirect}, 32'd0);
    chk("arst_empty", {31'd0, ras_empty}, 32'd1);
    stall = 1'b0; jump = 1'b0;
    #1 rst = 1'b0;
    step_pc("post_rst", 32'h4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined MIPS core, sitting at the head of IF. It holds the fetch PC and chooses the next PC by fixed priority among exception, EX-stage branch, ID-stage jump, return-address-stack prediction and sequential increment. Redirects that arrive while the pipeline is stalled are latched and applied on the first unstalled cycle. A small circular return-address stack (RAS) predicts `jr $ra` targets.

## Interface
- WIDTH, 32: PC width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080: exception handler entry.
- RAS_DEPTH, 4: RAS entries; power of two, at least 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold PC; replaces the old PCWrite enable (stall_i = ~PCWrite).
- exc_i  in  1  exception request; acts even when stall_i is high.
- br_taken_i  in  1  taken branch resolved in EX.
- br_target_i  in  WIDTH  branch target.
- jump_i  in  1  j/jal decoded in ID.
- jump_target_i  in  WIDTH  jump target.
- call_i  in  1  jal in ID; push call_link_i onto the RAS.
- call_link_i  in  WIDTH  link address to push.
- ret_i  in  1  `jr $ra` in ID; pop the RAS and redirect.
- pc_o  out  WIDTH  current fetch PC.
- pc_plus4_o  out  WIDTH  pc_o + 4, combinational, wraps modulo 2^WIDTH.
- redirect_o  out  1  registered; high for one cycle when pc_o was loaded by a non-sequential source.
- ras_empty_o  out  1  RAS count is 0.
- ras_full_o  out  1  RAS count equals RAS_DEPTH.

## Operation
- Reset values:
  - pc_o = RESET_VECTOR; redirect_o = 0.
  - Pending register invalid; RAS count = 0; RAS pointer = 0.
- Next-PC priority (highest first):
  1. exc_i → EXC_VECTOR.
  2. br_taken_i → br_target_i.
  3. Valid pending redirect → its stored target.
  4. jump_i → jump_target_i.
  5. ret_i with the RAS non-empty → top of stack.
  6. Otherwise → pc_plus4_o.
- exc_i:
  - Loads EXC_VECTOR regardless of stall_i.
  - Clears the pending register.
  - Blocks call_i and ret_i that cycle.
  - Leaves RAS contents unchanged.
- stall_i high and no exc_i:
  - pc_o holds.
  - A br_taken_i or jump_i is captured into the pending register with its target.
  - A br_taken_i overwrites any existing pending entry.
  - A jump_i is captured only if the pending register is empty.
  - call_i and ret_i are ignored.
- stall_i low:
  - The selected source loads pc_o.
  - The pending register is consumed (invalidated) when it is selected or overridden by exc_i or br_taken_i.
- RAS, evaluated only when stall_i = 0 and exc_i = 0:
  - ret_i on an empty RAS: no redirect, RAS unchanged; EX later corrects via br_taken_i.
  - ret_i is popped even when a higher-priority source wins that cycle.
  - call_i on a full RAS: overwrite the oldest entry (circular wrap); count stays at RAS_DEPTH.
  - call_i and ret_i in the same cycle: pop the top, push call_link_i in its place; count unchanged.
- redirect_o is 1 in the cycle after any load from sources 1–5; 0 after a sequential load or a hold.

## Timing
- One-cycle latency: a request sampled at edge N appears on pc_o after edge N.
- Pending redirect: applied at the first edge with stall_i = 0; redirect_o follows in the same cycle as the new pc_o.
- Asynchronous reset:
  - Assertion forces the reset values immediately, including mid-stall and with a pending redirect.
  - Deassertion: the first rising edge with rst_i low performs a normal update.
- pc_plus4_o, ras_empty_o and ras_full_o are combinational from registered state only; no input-to-output paths.

## Structure
- Shared package pc_pkg:
  - Enum redirect_src_t {SRC_SEQ, SRC_EXC, SRC_BR, SRC_PEND, SRC_JMP, SRC_RET}.
  - Localparam INSTR_BYTES = 4.
  - Default vector constants.
- Sub-module pc_ras:
  - Parameters WIDTH and RAS_DEPTH.
  - push/pop/data ports, empty/full flags.
  - Circular storage with a wrap-around pointer and a saturating count.
- pc_gen holds the PC register, the pending register (valid bit plus target) and the priority mux.

## Test plan
- Reset, then 3 unstalled cycles → pc_o = 0x0, 0x4, 0x8, 0xC; redirect_o stays 0.
- stall_i high for 2 cycles with jump_i (target 0x100) in the first stalled cycle → pc_o holds; after release pc_o = 0x100 and redirect_o = 1 for one cycle.
- Same cycle: br_taken_i (0x200), jump_i (0x300) and a pending entry (0x400) → pc_o = 0x200; pending cleared.
- exc_i asserted while stalled with pending 0x100 → pc_o = 0x80 next cycle; 0x100 is never fetched.
- RAS_DEPTH = 4, five calls with links 0x10–0x50 → ras_full_o = 1; five rets yield 0x50, 0x40, 0x30, 0x20; the fifth ret finds the RAS empty, takes no redirect and pc_o advances by 4.
- rst_i asserted mid-cycle during a stall with a pending redirect → pc_o = RESET_VECTOR immediately; pending cleared and ras_empty_o = 1.
